// File: rtl/cpu_storage.sv
`default_nettype none
// ============================================================================
// Module   : cpu_storage
// Purpose  : Instruction ROM, 32x32 register file (x0 = 0) and 32x32 data RAM
//            for a single-cycle RV32I datapath. Optional macro
//            REGFILE_BYPASS_EN adds register write-through on the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_storage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wren,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int              C_DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] C_NOP = DATA_W'(32'h0000_0013);

  logic [DATA_W-1:0] regs_q [C_DEPTH];
  logic [DATA_W-1:0] ram_q  [C_DEPTH];

  // Fixed boot program; any unlisted word is a nop.
  always_comb begin
    instr = C_NOP;
    case (pc)
      ADDR_W'(0): instr = DATA_W'(32'h0050_0093);
      ADDR_W'(1): instr = DATA_W'(32'h0070_0113);
      ADDR_W'(2): instr = DATA_W'(32'h0020_81B3);
      ADDR_W'(3): instr = DATA_W'(32'h0030_2223);
      ADDR_W'(4): instr = DATA_W'(32'h0040_2203);
      ADDR_W'(5): instr = DATA_W'(32'h0012_02B3);
      default:    instr = C_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_enable && (write_reg != '0)) begin
      regs_q[write_reg] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        ram_q[i] <= '0;
      end
    end else if (mem_wren) begin
      ram_q[mem_addr] <= mem_wdata;
    end
  end

  always_comb begin
    read_data1 = regs_q[read_reg1];
`ifdef REGFILE_BYPASS_EN
    if (write_enable && (write_reg != '0) && (write_reg == read_reg1)) begin
      read_data1 = write_data;
    end
`endif
    if (read_reg1 == '0) begin
      read_data1 = '0;
    end
  end

  always_comb begin
    read_data2 = regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (write_enable && (write_reg != '0) && (write_reg == read_reg2)) begin
      read_data2 = write_data;
    end
`endif
    if (read_reg2 == '0) begin
      read_data2 = '0;
    end
  end

  assign mem_rdata = ram_q[mem_addr];

endmodule
`default_nettype wire

// File: tb/tb_cpu_storage.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_storage
// Purpose  : Directed self-checking bench for cpu_storage with a reference
//            model of register file, RAM and ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_storage;

`ifdef REGFILE_BYPASS_EN
  localparam bit C_BYP = 1'b1;
`else
  localparam bit C_BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  pc;
  logic [31:0] instr;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] read_data1, read_data2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        write_enable;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  logic [31:0] m_reg [32];
  logic [31:0] m_ram [32];

  cpu_storage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_of(input logic [4:0] a);
    case (a)
      5'd0:    return 32'h0050_0093;
      5'd1:    return 32'h0070_0113;
      5'd2:    return 32'h0020_81B3;
      5'd3:    return 32'h0030_2223;
      5'd4:    return 32'h0040_2203;
      5'd5:    return 32'h0012_02B3;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic [31:0] reg_of(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (C_BYP && write_enable && write_reg == idx) return write_data;
    return m_reg[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 32'd0;
      m_ram[i] = 32'd0;
    end
  endtask

  // Model commits writes at each rising edge while out of reset.
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (write_enable && write_reg != 5'd0) m_reg[write_reg] = write_data;
      if (mem_wren) m_ram[mem_addr] = mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("instr",  instr,      rom_of(pc));
      chk("rdata1", read_data1, reg_of(read_reg1));
      chk("rdata2", read_data2, reg_of(read_reg2));
      chk("mrdata", mem_rdata,  m_ram[mem_addr]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ins, imm, addr_calc;

  initial begin
    rst_n = 1'b1; pc = '0; read_reg1 = '0; read_reg2 = '0;
    write_reg = '0; write_data = '0; write_enable = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wren = 1'b0;
    #2 rst_n = 1'b0;
    model_clear();
    started = 1'b1;
    step();
    rst_n = 1'b1;

    // ROM sweep against literal table
    for (int i = 0; i < 8; i++) begin
      step();
      pc = 5'(i);
      #1;
      case (i)
        0: chk("rom0", instr, 32'h0050_0093);
        1: chk("rom1", instr, 32'h0070_0113);
        2: chk("rom2", instr, 32'h0020_81B3);
        3: chk("rom3", instr, 32'h0030_2223);
        4: chk("rom4", instr, 32'h0040_2203);
        5: chk("rom5", instr, 32'h0012_02B3);
        default: chk("romnop", instr, 32'h0000_0013);
      endcase
    end

    // Register write / read, x0 discard, dual-port same index
    step(); write_enable = 1'b1; write_reg = 5'd1; write_data = 32'd5;
    step(); write_reg = 5'd2; write_data = 32'd7;
    step(); write_enable = 1'b0; read_reg1 = 5'd1; read_reg2 = 5'd2;
    #1 chk("x1", read_data1, 32'd5); chk("x2", read_data2, 32'd7);
    write_enable = 1'b1; write_reg = 5'd0; write_data = 32'hDEAD_BEEF;
    step(); write_enable = 1'b0; read_reg1 = 5'd0; read_reg2 = 5'd0;
    #1 chk("x0a", read_data1, 32'd0); chk("x0b", read_data2, 32'd0);
    read_reg1 = 5'd2; read_reg2 = 5'd2;
    #1 chk("same1", read_data1, 32'd7); chk("same2", read_data2, 32'd7);

    // RAM store / load
    step(); mem_wren = 1'b1; mem_addr = 5'd4; mem_wdata = 32'd12;
    step(); mem_wren = 1'b0;
    #1 chk("ram4", mem_rdata, 32'd12);
    mem_addr = 5'd5;
    #1 chk("ram5", mem_rdata, 32'd0);

    // Mid-operation asynchronous reset
    step(); write_enable = 1'b1; write_reg = 5'd3; write_data = 32'd12;
    mem_wren = 1'b1; mem_addr = 5'd4; mem_wdata = 32'd12;
    step(); write_enable = 1'b0; mem_wren = 1'b0; read_reg1 = 5'd3; pc = 5'd2;
    #1 chk("x3pre", read_data1, 32'd12); chk("ram4pre", mem_rdata, 32'd12);
    rst_n = 1'b0;
    model_clear();
    #1 chk("x3rst", read_data1, 32'd0); chk("ram4rst", mem_rdata, 32'd0);
    chk("instr_rst", instr, 32'h0020_81B3);
    write_enable = 1'b1; write_reg = 5'd7; write_data = 32'd9;
    step(); rst_n = 1'b1; write_reg = 5'd8; write_data = 32'h33;
    step(); write_enable = 1'b0; read_reg1 = 5'd7; read_reg2 = 5'd8;
    #1 chk("x7ign", read_data1, 32'd0); chk("x8deassert", read_data2, 32'h33);

    // Same-cycle collisions
    step(); write_enable = 1'b1; write_reg = 5'd6; write_data = 32'h55; read_reg1 = 5'd6;
    mem_wren = 1'b1; mem_addr = 5'd9; mem_wdata = 32'hA5;
    #1 chk("coll_pre", read_data1, C_BYP ? 32'h55 : 32'h0);
    chk("mcoll_pre", mem_rdata, 32'd0);
    step(); write_enable = 1'b0; mem_wren = 1'b0;
    #1 chk("coll_post", read_data1, 32'h55); chk("mcoll_post", mem_rdata, 32'hA5);

    // Program walk with an external add/mux datapath
    step(); rst_n = 1'b0; model_clear();
    step(); rst_n = 1'b1;
    for (int p = 0; p < 6; p++) begin
      if (p != 0) step();
      pc = 5'(p); write_enable = 1'b0; mem_wren = 1'b0;
      #1 ins = instr;
      read_reg1 = ins[19:15]; read_reg2 = ins[24:20];
      #1;
      case (ins[6:0])
        7'h13: begin
          imm = {{20{ins[31]}}, ins[31:20]};
          write_reg = ins[11:7]; write_data = read_data1 + imm; write_enable = 1'b1;
        end
        7'h33: begin
          write_reg = ins[11:7]; write_data = read_data1 + read_data2; write_enable = 1'b1;
        end
        7'h23: begin
          imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
          addr_calc = read_data1 + imm;
          mem_addr = addr_calc[4:0]; mem_wdata = read_data2; mem_wren = 1'b1;
        end
        7'h03: begin
          imm = {{20{ins[31]}}, ins[31:20]};
          addr_calc = read_data1 + imm;
          mem_addr = addr_calc[4:0];
          #1 write_reg = ins[11:7]; write_data = mem_rdata; write_enable = 1'b1;
        end
        default: ;
      endcase
    end
    step(); write_enable = 1'b0; mem_wren = 1'b0;
    read_reg1 = 5'd5; read_reg2 = 5'd3; mem_addr = 5'd4;
    #1 chk("prog_x5", read_data1, 32'd17); chk("prog_x3", read_data2, 32'd12);
    chk("prog_ram4", mem_rdata, 32'd12);

    step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
